vx_commit_arb: RTL and testbench
================================

VX_COMMIT_ARB -- requirements
Module: VX_commit_arb

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 6: number of commit input channels, legal range 2..8.
REQ-002 SHALL have parameter NUM_THREADS, default 4: lanes per commit.
REQ-003 SHALL have parameter WB_MASK, default 6'b101111: bit i=1 means channel i may write back; bit i=0 means channel i only retires.
REQ-004 SHALL have parameter NW_BITS, default 2: warp-id width.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 reset  input  1  reset; asynchronous, active-low.
REQ-007 in_valid  input  NUM_CHANNELS  per-channel commit request.
REQ-008 in_ready  output  NUM_CHANNELS  per-channel accept.
REQ-009 in_wid  input  NUM_CHANNELS*NW_BITS  warp id.
REQ-010 in_tmask  input  NUM_CHANNELS*NUM_THREADS  active lanes.
REQ-011 in_wb  input  NUM_CHANNELS  writeback request.
REQ-012 in_rd  input  NUM_CHANNELS*5  destination register.
REQ-013 in_data  input  NUM_CHANNELS*NUM_THREADS*32  result data.
REQ-014 wb_valid/wb_ready  output/input  1/1  writeback handshake.
REQ-015 wb_wid, wb_tmask, wb_rd, wb_data  output  NW_BITS, NUM_THREADS, 5, NUM_THREADS*32  writeback payload.
REQ-016 cmt_valid  output  1  retirement event for CSRs.
REQ-017 cmt_size  output  $clog2(NUM_CHANNELS*NUM_THREADS+1)  lanes retired in the event.

Function
REQ-018 A channel fires when in_valid[i] && in_ready[i].
REQ-019 in_ready[i] SHALL be 1 when WB_MASK[i]=0, or when in_wb[i]=0; these commits never enter arbitration.
REQ-020 Among channels with in_valid && in_wb && WB_MASK set, a round-robin arbiter SHALL grant at most one per cycle; in_ready for that channel = grant && (!wb_valid || wb_ready).
REQ-021 Round-robin pointer SHALL advance to (granted index + 1) mod NUM_CHANNELS only on a granted fire; otherwise it holds.
REQ-022 Search SHALL start at the pointer and wrap past NUM_CHANNELS-1 to 0.
REQ-023 The writeback output register SHALL load the granted payload one cycle after fire (latency 1); it holds while wb_valid && !wb_ready.
REQ-024 Simultaneous drain and load SHALL sustain one writeback per cycle with no bubble.
REQ-025 cmt_size SHALL be the sum of the popcounts of in_tmask over all channels firing in the cycle, registered one cycle; cmt_valid = 1 if any channel fired the previous cycle, else 0 with cmt_size 0.
REQ-026 tmask=0 commits SHALL still assert cmt_valid with contribution 0.
REQ-027 Output payload SHALL not change while wb_valid && !wb_ready.

Reset
REQ-028 On reset low, SHALL asynchronously clear: wb_valid=0, cmt_valid=0, cmt_size=0, pointer=0, perf counter=0; payload registers are don't-care.
REQ-029 Reset mid-transfer SHALL drop the buffered writeback; in_ready SHALL be 0 for arbitrated channels while reset is asserted.

Configuration
REQ-030 With VX_COMMIT_PERF_EN defined, SHALL add output perf_instrs (64 bits), incremented by the pre-register lane sum each cycle and wrapping modulo 2^64.
REQ-031 Without VX_COMMIT_PERF_EN, perf_instrs and its counter SHALL not exist; all other behaviour is identical.

Structure
REQ-032 The rd width (5), data width (32) and the cmt_size width function SHALL live in the shared VX_gpu_pkg.
REQ-033 The round-robin arbiter SHALL be sub-module VX_rr_arbiter (NUM_REQS parameter, requests/grant one-hot/grant_valid/enable).

Verification
REQ-034 Channels 0, 1 and 2 valid with wb=1, wb_ready=1 -> grants 0, 1, 2 in consecutive cycles; wb_valid high for 3 cycles starting 1 cycle later.
REQ-035 Channel 4 (WB_MASK=0) with tmask=4'b1111 and channel 0 with tmask=4'b0011 firing together -> next cycle cmt_valid=1, cmt_size=6.
REQ-036 wb_ready held 0 for 5 cycles with channel 1 pending -> wb payload stable, in_ready[1]=0 until wb_ready returns.
REQ-037 Pointer at 5 with requests on 5 and 0 -> grant 5, then 0 (wrap).
REQ-038 Reset asserted while wb_valid=1 -> wb_valid and cmt_valid fall immediately, with no clock edge required.
REQ-039 With VX_COMMIT_PERF_EN, 10 cycles of one full-mask commit each -> perf_instrs=40.

Source files
------------

// File: rtl/vx_commit_arb_pkg.sv
// Shared commit-path constants: register index width, lane data width and the
// width helper for the retirement lane count.
package vx_commit_arb_pkg;

    localparam int unsigned RD_BITS   = 5;
    localparam int unsigned DATA_BITS = 32;

    function automatic int unsigned cmt_size_width(input int unsigned num_channels,
                                                   input int unsigned num_threads);
        return $clog2(num_channels * num_threads + 1);
    endfunction

endpackage

// File: rtl/vx_commit_arb_if.sv
// Commit-channel bundle: per-channel commit requests in, one writeback stream
// and one retirement event out.
interface vx_commit_arb_if #(
    parameter int unsigned NUM_CHANNELS = 6,
    parameter int unsigned NUM_THREADS  = 4,
    parameter int unsigned NW_BITS      = 2
);
    import vx_commit_arb_pkg::*;

    localparam int unsigned CMT_W = cmt_size_width(NUM_CHANNELS, NUM_THREADS);

    logic [NUM_CHANNELS-1:0]                       in_valid;
    logic [NUM_CHANNELS-1:0]                       in_ready;
    logic [NUM_CHANNELS*NW_BITS-1:0]               in_wid;
    logic [NUM_CHANNELS*NUM_THREADS-1:0]           in_tmask;
    logic [NUM_CHANNELS-1:0]                       in_wb;
    logic [NUM_CHANNELS*RD_BITS-1:0]               in_rd;
    logic [NUM_CHANNELS*NUM_THREADS*DATA_BITS-1:0] in_data;

    logic                             wb_valid;
    logic                             wb_ready;
    logic [NW_BITS-1:0]               wb_wid;
    logic [NUM_THREADS-1:0]           wb_tmask;
    logic [RD_BITS-1:0]               wb_rd;
    logic [NUM_THREADS*DATA_BITS-1:0] wb_data;

    logic             cmt_valid;
    logic [CMT_W-1:0] cmt_size;

    modport master (
        output in_valid, in_wid, in_tmask, in_wb, in_rd, in_data, wb_ready,
        input  in_ready, wb_valid, wb_wid, wb_tmask, wb_rd, wb_data, cmt_valid, cmt_size
    );

    modport slave (
        input  in_valid, in_wid, in_tmask, in_wb, in_rd, in_data, wb_ready,
        output in_ready, wb_valid, wb_wid, wb_tmask, wb_rd, wb_data, cmt_valid, cmt_size
    );

endinterface

// File: rtl/vx_commit_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the pointer upward with wrap;
// the pointer moves past the winner only when the grant is consumed (enable).
module vx_commit_arb_rr_arbiter #(
    parameter int unsigned NUM_REQS = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] requests,
    input  logic                enable,
    output logic [NUM_REQS-1:0] grant,
    output logic                grant_valid
);

    localparam int unsigned IDX_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;
    logic             hi_hit;
    logic             lo_hit;

    // Descending scan keeps the lowest index per half; the half at/above the
    // pointer wins over the wrapped half below it.
    always_comb begin
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            if (requests[i]) begin
                if (IDX_W'(i) >= ptr_q) begin
                    hi_hit = 1'b1;
                    hi_idx = IDX_W'(i);
                end else begin
                    lo_hit = 1'b1;
                    lo_idx = IDX_W'(i);
                end
            end
        end
        grant_valid = hi_hit || lo_hit;
        grant_idx   = hi_hit ? hi_idx : lo_idx;
        grant       = grant_valid ? (NUM_REQS'(1) << grant_idx) : '0;
        ptr_d       = (grant_idx == IDX_W'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else if (enable && grant_valid) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/vx_commit_arb.sv
// Commit arbiter: retire-only commits pass straight through, writeback commits
// share one registered writeback port; VX_COMMIT_PERF_EN adds perf_instrs.
module vx_commit_arb
    import vx_commit_arb_pkg::*;
#(
    parameter int unsigned             NUM_CHANNELS = 6,
    parameter int unsigned             NUM_THREADS  = 4,
    parameter logic [NUM_CHANNELS-1:0] WB_MASK      = 6'b101111,
    parameter int unsigned             NW_BITS      = 2
) (
    input logic            clk,
    input logic            reset,
    vx_commit_arb_if.slave bus
`ifdef VX_COMMIT_PERF_EN
    ,
    output logic [63:0]    perf_instrs
`endif
);

    localparam int unsigned CMT_W = cmt_size_width(NUM_CHANNELS, NUM_THREADS);

    logic [NUM_CHANNELS-1:0] arb_req;
    logic [NUM_CHANNELS-1:0] grant;
    logic [NUM_CHANNELS-1:0] ready;
    logic [NUM_CHANNELS-1:0] fire;
    logic                    grant_valid;
    logic                    can_load;
    logic                    arb_fire;
    logic [CMT_W-1:0]        lane_sum;

    logic [NW_BITS-1:0]               sel_wid;
    logic [NUM_THREADS-1:0]           sel_tmask;
    logic [RD_BITS-1:0]               sel_rd;
    logic [NUM_THREADS*DATA_BITS-1:0] sel_data;

    logic                             wb_valid_q;
    logic [NW_BITS-1:0]               wb_wid_q;
    logic [NUM_THREADS-1:0]           wb_tmask_q;
    logic [RD_BITS-1:0]               wb_rd_q;
    logic [NUM_THREADS*DATA_BITS-1:0] wb_data_q;
    logic                             cmt_valid_q;
    logic [CMT_W-1:0]                 cmt_size_q;

    assign arb_req  = bus.in_valid & bus.in_wb & WB_MASK;
    assign can_load = !wb_valid_q || bus.wb_ready;
    // Reset low blocks arbitrated accepts so nothing is lost into a cleared buffer.
    assign arb_fire = grant_valid && can_load && reset;

    vx_commit_arb_rr_arbiter #(
        .NUM_REQS (NUM_CHANNELS)
    ) u_rr_arbiter (
        .clk         (clk),
        .reset       (reset),
        .requests    (arb_req),
        .enable      (arb_fire),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    always_comb begin
        ready = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (!WB_MASK[i] || !bus.in_wb[i]) begin
                ready[i] = 1'b1;
            end else begin
                ready[i] = grant[i] && can_load && reset;
            end
        end
    end

    assign fire         = bus.in_valid & ready;
    assign bus.in_ready = ready;

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (fire[i]) begin
                    lane_sum = lane_sum + CMT_W'(bus.in_tmask[i*NUM_THREADS + t]);
                end
            end
        end
    end

    // One-hot grant: OR of masked channel fields selects the payload.
    always_comb begin
        sel_wid   = '0;
        sel_tmask = '0;
        sel_rd    = '0;
        sel_data  = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (grant[i]) begin
                sel_wid   = sel_wid   | bus.in_wid[i*NW_BITS +: NW_BITS];
                sel_tmask = sel_tmask | bus.in_tmask[i*NUM_THREADS +: NUM_THREADS];
                sel_rd    = sel_rd    | bus.in_rd[i*RD_BITS +: RD_BITS];
                sel_data  = sel_data  | bus.in_data[i*NUM_THREADS*DATA_BITS +: NUM_THREADS*DATA_BITS];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_valid_q  <= 1'b0;
            cmt_valid_q <= 1'b0;
            cmt_size_q  <= '0;
        end else begin
            if (can_load) begin
                wb_valid_q <= grant_valid;
            end
            cmt_valid_q <= |fire;
            cmt_size_q  <= lane_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (arb_fire) begin
            wb_wid_q   <= sel_wid;
            wb_tmask_q <= sel_tmask;
            wb_rd_q    <= sel_rd;
            wb_data_q  <= sel_data;
        end
    end

    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_wid    = wb_wid_q;
    assign bus.wb_tmask  = wb_tmask_q;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.cmt_valid = cmt_valid_q;
    assign bus.cmt_size  = cmt_size_q;

`ifdef VX_COMMIT_PERF_EN
    logic [63:0] perf_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_q + 64'(lane_sum);
        end
    end

    assign perf_instrs = perf_q;
`endif

endmodule

// File: tb/tb_vx_commit_arb.sv
// Directed bench for vx_commit_arb (default parameters); perf checks only when
// VX_COMMIT_PERF_EN is defined.
module tb_vx_commit_arb;

    localparam int unsigned NC = 6;
    localparam int unsigned NT = 4;
    localparam int unsigned NW = 2;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    vx_commit_arb_if #(.NUM_CHANNELS(NC), .NUM_THREADS(NT), .NW_BITS(NW)) bus ();

`ifdef VX_COMMIT_PERF_EN
    logic [63:0] perf_instrs;
`endif

    vx_commit_arb dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef VX_COMMIT_PERF_EN
        ,
        .perf_instrs (perf_instrs)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.in_valid = '0;
        bus.in_wb    = '0;
        bus.in_wid   = '0;
        bus.in_tmask = '0;
        bus.in_rd    = '0;
        bus.in_data  = '0;
    endtask

    task automatic set_ch(input int ch, input logic wb, input logic [NW-1:0] wid,
                          input logic [NT-1:0] tmask, input logic [4:0] rd,
                          input logic [31:0] base);
        bus.in_valid[ch]         = 1'b1;
        bus.in_wb[ch]            = wb;
        bus.in_wid[ch*NW +: NW]  = wid;
        bus.in_tmask[ch*NT +: NT] = tmask;
        bus.in_rd[ch*5 +: 5]     = rd;
        for (int l = 0; l < NT; l++) bus.in_data[(ch*NT + l)*32 +: 32] = base + 32'(l);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.wb_ready = 1'b1;
        clear_inputs();
        set_ch(0, 1'b1, 2'd0, 4'b1111, 5'd1, 32'd5);
        #1;
        vectors++; if (bus.wb_valid !== 1'b0) begin miscompares++; $display("FAIL reset wb_valid: got %b want 0", bus.wb_valid); end
        vectors++; if (bus.cmt_valid !== 1'b0) begin miscompares++; $display("FAIL reset cmt_valid: got %b want 0", bus.cmt_valid); end
        vectors++; if (bus.cmt_size !== 5'd0) begin miscompares++; $display("FAIL reset cmt_size: got %0d want 0", bus.cmt_size); end
        vectors++; if (bus.in_ready[0] !== 1'b0) begin miscompares++; $display("FAIL reset in_ready[0]: got %b want 0", bus.in_ready[0]); end
        vectors++; if (bus.in_ready[4] !== 1'b1) begin miscompares++; $display("FAIL reset in_ready[4]: got %b want 1", bus.in_ready[4]); end
`ifdef VX_COMMIT_PERF_EN
        vectors++; if (perf_instrs !== 64'd0) begin miscompares++; $display("FAIL reset perf: got %0d want 0", perf_instrs); end
`endif
        tick();
        tick();
        vectors++; if (bus.wb_valid !== 1'b0) begin miscompares++; $display("FAIL reset hold wb_valid: got %b want 0", bus.wb_valid); end
        clear_inputs();
        reset = 1'b1;
        tick();
        vectors++; if (bus.cmt_valid !== 1'b0) begin miscompares++; $display("FAIL post-reset cmt_valid: got %b want 0", bus.cmt_valid); end
    endtask

    // Channels 0,1,2 together: grants 0,1,2 back to back, no writeback bubble.
    task automatic test_rr_sequence();
        logic [NC-1:0] exp_fire;
        logic [31:0]   base;
        clear_inputs();
        set_ch(0, 1'b1, 2'd0, 4'b0001, 5'd1, 32'd100);
        set_ch(1, 1'b1, 2'd1, 4'b0011, 5'd2, 32'd200);
        set_ch(2, 1'b1, 2'd2, 4'b0111, 5'd3, 32'd300);
        for (int k = 0; k < 3; k++) begin
            exp_fire = NC'(1) << k;
            base     = 32'd100 * 32'(k + 1);
            #1;
            vectors++; if ((bus.in_ready & bus.in_valid) !== exp_fire) begin miscompares++; $display("FAIL rr fire k=%0d: got %b want %b", k, bus.in_ready & bus.in_valid, exp_fire); end
            tick();
            bus.in_valid[k] = 1'b0;
            vectors++; if (bus.wb_valid !== 1'b1) begin miscompares++; $display("FAIL rr wb_valid k=%0d: got %b want 1", k, bus.wb_valid); end
            vectors++; if (bus.wb_rd !== 5'(k + 1)) begin miscompares++; $display("FAIL rr wb_rd k=%0d: got %0d want %0d", k, bus.wb_rd, k + 1); end
            vectors++; if (bus.wb_data[31:0] !== base) begin miscompares++; $display("FAIL rr wb_data0 k=%0d: got %0d want %0d", k, bus.wb_data[31:0], base); end
            vectors++; if (bus.wb_data[127:96] !== base + 32'd3) begin miscompares++; $display("FAIL rr wb_data3 k=%0d: got %0d want %0d", k, bus.wb_data[127:96], base + 32'd3); end
            vectors++; if (bus.cmt_size !== 5'(k + 1)) begin miscompares++; $display("FAIL rr cmt_size k=%0d: got %0d want %0d", k, bus.cmt_size, k + 1); end
        end
        clear_inputs();
        tick();
        vectors++; if (bus.wb_valid !== 1'b0) begin miscompares++; $display("FAIL rr drain wb_valid: got %b want 0", bus.wb_valid); end
        vectors++; if (bus.cmt_valid !== 1'b0) begin miscompares++; $display("FAIL rr idle cmt_valid: got %b want 0", bus.cmt_valid); end
    endtask

    // Retire-only channel 4 plus writeback channel 0, then a zero-mask retire.
    task automatic test_cmt_size();
        clear_inputs();
        set_ch(4, 1'b1, 2'd1, 4'b1111, 5'd4, 32'd400);
        set_ch(0, 1'b1, 2'd2, 4'b0011, 5'd10, 32'd1000);
        #1;
        vectors++; if ((bus.in_ready & bus.in_valid) !== 6'b010001) begin miscompares++; $display("FAIL cmt fire: got %b want 010001", bus.in_ready & bus.in_valid); end
        tick();
        clear_inputs();
        vectors++; if (bus.cmt_valid !== 1'b1) begin miscompares++; $display("FAIL cmt cmt_valid: got %b want 1", bus.cmt_valid); end
        vectors++; if (bus.cmt_size !== 5'd6) begin miscompares++; $display("FAIL cmt cmt_size: got %0d want 6", bus.cmt_size); end
        vectors++; if (bus.wb_rd !== 5'd10) begin miscompares++; $display("FAIL cmt wb_rd: got %0d want 10", bus.wb_rd); end
        vectors++; if (bus.wb_wid !== 2'd2) begin miscompares++; $display("FAIL cmt wb_wid: got %0d want 2", bus.wb_wid); end
        vectors++; if (bus.wb_tmask !== 4'b0011) begin miscompares++; $display("FAIL cmt wb_tmask: got %b want 0011", bus.wb_tmask); end
        set_ch(3, 1'b0, 2'd0, 4'b0000, 5'd3, 32'd0);
        #1;
        vectors++; if ((bus.in_ready & bus.in_valid) !== 6'b001000) begin miscompares++; $display("FAIL zero-mask fire: got %b want 001000", bus.in_ready & bus.in_valid); end
        tick();
        clear_inputs();
        vectors++; if (bus.cmt_valid !== 1'b1) begin miscompares++; $display("FAIL zero-mask cmt_valid: got %b want 1", bus.cmt_valid); end
        vectors++; if (bus.cmt_size !== 5'd0) begin miscompares++; $display("FAIL zero-mask cmt_size: got %0d want 0", bus.cmt_size); end
        vectors++; if (bus.wb_valid !== 1'b0) begin miscompares++; $display("FAIL zero-mask wb_valid: got %b want 0", bus.wb_valid); end
        tick();
    endtask

    // Full buffer with wb_ready low: payload frozen, pending channel 1 stalled.
    task automatic test_backpressure();
        clear_inputs();
        bus.wb_ready = 1'b0;
        set_ch(2, 1'b1, 2'd1, 4'b1111, 5'd7, 32'd700);
        #1;
        vectors++; if ((bus.in_ready & bus.in_valid) !== 6'b000100) begin miscompares++; $display("FAIL bp load fire: got %b want 000100", bus.in_ready & bus.in_valid); end
        tick();
        clear_inputs();
        set_ch(1, 1'b1, 2'd3, 4'b1010, 5'd9, 32'd900);
        for (int c = 0; c < 5; c++) begin
            #1;
            vectors++; if (bus.in_ready[1] !== 1'b0) begin miscompares++; $display("FAIL bp in_ready[1] c=%0d: got %b want 0", c, bus.in_ready[1]); end
            vectors++; if (bus.wb_valid !== 1'b1) begin miscompares++; $display("FAIL bp wb_valid c=%0d: got %b want 1", c, bus.wb_valid); end
            vectors++; if (bus.wb_rd !== 5'd7) begin miscompares++; $display("FAIL bp wb_rd c=%0d: got %0d want 7", c, bus.wb_rd); end
            vectors++; if (bus.wb_data[31:0] !== 32'd700) begin miscompares++; $display("FAIL bp wb_data c=%0d: got %0d want 700", c, bus.wb_data[31:0]); end
            tick();
        end
        bus.wb_ready = 1'b1;
        #1;
        vectors++; if (bus.in_ready[1] !== 1'b1) begin miscompares++; $display("FAIL bp release in_ready[1]: got %b want 1", bus.in_ready[1]); end
        tick();
        clear_inputs();
        vectors++; if (bus.wb_valid !== 1'b1) begin miscompares++; $display("FAIL bp reload wb_valid: got %b want 1", bus.wb_valid); end
        vectors++; if (bus.wb_rd !== 5'd9) begin miscompares++; $display("FAIL bp reload wb_rd: got %0d want 9", bus.wb_rd); end
        vectors++; if (bus.wb_tmask !== 4'b1010) begin miscompares++; $display("FAIL bp reload wb_tmask: got %b want 1010", bus.wb_tmask); end
        vectors++; if (bus.cmt_size !== 5'd2) begin miscompares++; $display("FAIL bp reload cmt_size: got %0d want 2", bus.cmt_size); end
        tick();
        vectors++; if (bus.wb_valid !== 1'b0) begin miscompares++; $display("FAIL bp drain wb_valid: got %b want 0", bus.wb_valid); end
    endtask

    // Pointer past channel 3, requests on 5 and 0: 5 first, then wrap to 0.
    task automatic test_wrap();
        clear_inputs();
        set_ch(3, 1'b1, 2'd0, 4'b0001, 5'd3, 32'd30);
        #1;
        vectors++; if ((bus.in_ready & bus.in_valid) !== 6'b001000) begin miscompares++; $display("FAIL wrap pre fire: got %b want 001000", bus.in_ready & bus.in_valid); end
        tick();
        clear_inputs();
        set_ch(5, 1'b1, 2'd1, 4'b0001, 5'd5, 32'd50);
        set_ch(0, 1'b1, 2'd0, 4'b0001, 5'd11, 32'd110);
        #1;
        vectors++; if ((bus.in_ready & bus.in_valid) !== 6'b100000) begin miscompares++; $display("FAIL wrap fire5: got %b want 100000", bus.in_ready & bus.in_valid); end
        tick();
        bus.in_valid[5] = 1'b0;
        vectors++; if (bus.wb_rd !== 5'd5) begin miscompares++; $display("FAIL wrap wb_rd5: got %0d want 5", bus.wb_rd); end
        #1;
        vectors++; if ((bus.in_ready & bus.in_valid) !== 6'b000001) begin miscompares++; $display("FAIL wrap fire0: got %b want 000001", bus.in_ready & bus.in_valid); end
        tick();
        clear_inputs();
        vectors++; if (bus.wb_rd !== 5'd11) begin miscompares++; $display("FAIL wrap wb_rd0: got %0d want 11", bus.wb_rd); end
        tick();
    endtask

    // Asynchronous reset drops a buffered writeback without a clock edge.
    task automatic test_reset_mid();
        clear_inputs();
        bus.wb_ready = 1'b0;
        set_ch(0, 1'b1, 2'd0, 4'b0001, 5'd1, 32'd10);
        tick();
        clear_inputs();
        vectors++; if (bus.wb_valid !== 1'b1) begin miscompares++; $display("FAIL mid pre wb_valid: got %b want 1", bus.wb_valid); end
        #2;
        reset = 1'b0;
        set_ch(1, 1'b1, 2'd1, 4'b0001, 5'd2, 32'd20);
        #1;
        vectors++; if (bus.wb_valid !== 1'b0) begin miscompares++; $display("FAIL mid async wb_valid: got %b want 0", bus.wb_valid); end
        vectors++; if (bus.cmt_valid !== 1'b0) begin miscompares++; $display("FAIL mid async cmt_valid: got %b want 0", bus.cmt_valid); end
        vectors++; if (bus.cmt_size !== 5'd0) begin miscompares++; $display("FAIL mid async cmt_size: got %0d want 0", bus.cmt_size); end
        vectors++; if (bus.in_ready[1] !== 1'b0) begin miscompares++; $display("FAIL mid in_ready[1]: got %b want 0", bus.in_ready[1]); end
        tick();
        clear_inputs();
        bus.wb_ready = 1'b1;
        reset = 1'b1;
        tick();
        vectors++; if (bus.wb_valid !== 1'b0) begin miscompares++; $display("FAIL mid after wb_valid: got %b want 0", bus.wb_valid); end
    endtask

`ifdef VX_COMMIT_PERF_EN
    task automatic test_perf();
        clear_inputs();
        reset = 1'b0;
        #1;
        reset = 1'b1;
        vectors++; if (perf_instrs !== 64'd0) begin miscompares++; $display("FAIL perf cleared: got %0d want 0", perf_instrs); end
        set_ch(4, 1'b0, 2'd0, 4'b1111, 5'd0, 32'd0);
        repeat (10) tick();
        clear_inputs();
        vectors++; if (perf_instrs !== 64'd40) begin miscompares++; $display("FAIL perf count: got %0d want 40", perf_instrs); end
        tick();
        vectors++; if (perf_instrs !== 64'd40) begin miscompares++; $display("FAIL perf hold: got %0d want 40", perf_instrs); end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_rr_sequence();
        test_cmt_size();
        test_backpressure();
        test_wrap();
        test_reset_mid();
`ifdef VX_COMMIT_PERF_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
